// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 decoder: turns E0/F0 prefix sequences into make/break
// events, filters typematic repeats of the held key, and queues events in a
// first-word-fall-through FIFO with a valid/ready consumer interface.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_code,
    output logic             out_ext,
    output logic             out_break,
    output logic             overflow,
    output logic             key_down,
    output logic [CNT_W-1:0] press_count
);

    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PTR_W = AW + 1;

    localparam logic [7:0] CODE_E0  = 8'hE0;
    localparam logic [7:0] CODE_F0  = 8'hF0;
    localparam logic [7:0] CODE_ERR0 = 8'h00;
    localparam logic [7:0] CODE_ERR1 = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        S_E0   = 2'd1,
        S_F0   = 2'd2,
        S_E0F0 = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         held_code_q, held_code_d;
    logic               held_ext_q, held_ext_d;
    logic               held_valid_q, held_valid_d;
    logic [CNT_W-1:0]   press_count_q, press_count_d;
    logic               overflow_q, overflow_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

    // Event FIFO storage: {ext, brk, code}; read asynchronously for fall-through
    logic [9:0]         fifo_mem [FIFO_DEPTH];

    // Decoded event from the current byte (valid only in the byte's cycle)
    logic               ev_valid;
    logic               ev_ext;
    logic               ev_brk;
    logic [7:0]         ev_code;
    logic               held_match;
    logic               suppress;
    logic               ev_push_req;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pop;
    logic               push;
    logic [9:0]         head;

    // Prefix state machine: decide next state and which event this byte yields
    always_comb begin
        state_d  = state_q;
        ev_valid = 1'b0;
        ev_ext   = 1'b0;
        ev_brk   = 1'b0;
        ev_code  = in_data;
        if (in_valid) begin
            case (state_q)
                IDLE: begin
                    if (in_data == CODE_E0) begin
                        state_d = S_E0;
                    end else if (in_data == CODE_F0) begin
                        state_d = S_F0;
                    end else if (in_data == CODE_ERR0 || in_data == CODE_ERR1) begin
                        state_d = IDLE;
                    end else begin
                        ev_valid = 1'b1;
                    end
                end
                S_E0: begin
                    if (in_data == CODE_F0) begin
                        state_d = S_E0F0;
                    end else if (in_data == CODE_E0) begin
                        state_d = S_E0;
                    end else begin
                        ev_valid = 1'b1;
                        ev_ext   = 1'b1;
                        state_d  = IDLE;
                    end
                end
                S_F0: begin
                    if (in_data == CODE_F0) begin
                        state_d = S_F0;
                    end else if (in_data == CODE_E0) begin
                        // A stray E0 after F0 restarts an extended sequence
                        state_d = S_E0;
                    end else begin
                        ev_valid = 1'b1;
                        ev_brk   = 1'b1;
                        state_d  = IDLE;
                    end
                end
                S_E0F0: begin
                    if (in_data == CODE_E0 || in_data == CODE_F0) begin
                        // Malformed sequence, nothing is emitted
                        state_d = IDLE;
                    end else begin
                        ev_valid = 1'b1;
                        ev_ext   = 1'b1;
                        ev_brk   = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Repeat filter and held-key tracking; press counter counts every unsuppressed make
    always_comb begin
        held_code_d   = held_code_q;
        held_ext_d    = held_ext_q;
        held_valid_d  = held_valid_q;
        press_count_d = press_count_q;
        held_match    = held_valid_q && (held_code_q == ev_code) && (held_ext_q == ev_ext);
        suppress      = ev_valid && !ev_brk && held_match;
        ev_push_req   = ev_valid && !suppress;
        if (ev_valid && !ev_brk && !suppress) begin
            held_code_d   = ev_code;
            held_ext_d    = ev_ext;
            held_valid_d  = 1'b1;
            press_count_d = press_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (ev_valid && ev_brk && held_match) begin
            held_valid_d = 1'b0;
        end
    end

    // FIFO pointer control; a pop in the same cycle frees room for a push into a full FIFO
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = !fifo_empty && out_ready;
        push       = ev_push_req && (!fifo_full || pop);
        overflow_d = overflow_q || (ev_push_req && fifo_full && !pop);
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= IDLE;
            held_code_q   <= 8'h00;
            held_ext_q    <= 1'b0;
            held_valid_q  <= 1'b0;
            press_count_q <= '0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            held_code_q   <= held_code_d;
            held_ext_q    <= held_ext_d;
            held_valid_q  <= held_valid_d;
            press_count_q <= press_count_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // FIFO storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= {ev_ext, ev_brk, ev_code};
        end
    end

    // Head of queue; fields forced to zero while empty so reset shows all-zero outputs
    always_comb begin
        head      = fifo_mem[rd_ptr_q[AW-1:0]];
        out_valid = !fifo_empty;
        out_code  = out_valid ? head[7:0] : 8'h00;
        out_break = out_valid ? head[8]   : 1'b0;
        out_ext   = out_valid ? head[9]   : 1'b0;
    end

    assign overflow    = overflow_q;
    assign key_down    = held_valid_q;
    assign press_count = press_count_q;

endmodule
